vga_timing_gen: RTL and testbench

- Parametrised successor of the fixed 640x480@72Hz sync generator.
- Produces registered hsync, vsync, active-video and pixel coordinates for any mode, with programmable sync polarity and line/frame start strobes.
- Counters advance only on px_en cycles, so an upstream pixel source can stall the raster.
- Sits between the pixel clock domain and the pixel-fetch/colour logic of the VGA player.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: registered sync, active-video, coordinates and line/frame strobes.
// Optional FRAME_CNT_EN macro adds an 8-bit frame counter port.
module vga_timing_gen #(
  parameter int unsigned CW       = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 128,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 9,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 28,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic          px_clk,
  input  logic          reset,
  input  logic          px_en,
  output logic          hsync,
  output logic          vsync,
  output logic          activevideo,
  output logic [CW-1:0] x_px,
  output logic [CW-1:0] y_px,
  output logic          line_start,
  output logic          frame_start
`ifdef FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;

  localparam logic [CW-1:0] H_SYNC_LO = CW'(H_FP);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(H_FP + H_SYNC);
  localparam logic [CW-1:0] H_BLANK_W = CW'(H_BLANK);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_SYNC_LO = CW'(V_FP);
  localparam logic [CW-1:0] V_SYNC_HI = CW'(V_FP + V_SYNC);
  localparam logic [CW-1:0] V_BLANK_W = CW'(V_BLANK);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          hs_act_c;
  logic          vs_act_c;
  logic          av_c;
  logic          line_c;
  logic          frame_c;
  logic [CW-1:0] x_c;
  logic [CW-1:0] y_c;

  // Decode of the current raster position; loaded into the outputs on px_en edges.
  always_comb begin
    hs_act_c = (hc >= H_SYNC_LO) && (hc < H_SYNC_HI);
    vs_act_c = (vc >= V_SYNC_LO) && (vc < V_SYNC_HI);
    av_c     = (hc >= H_BLANK_W) && (vc >= V_BLANK_W);
    line_c   = (hc == '0);
    frame_c  = (hc == '0) && (vc == '0);
    x_c      = '0;
    y_c      = '0;
    if (av_c) begin
      x_c = hc - H_BLANK_W;
      y_c = vc - V_BLANK_W;
    end
  end

  // Raster counters and registered outputs; strobes drop on stall cycles.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      activevideo <= 1'b0;
      x_px        <= '0;
      y_px        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (px_en) begin
      hsync       <= hs_act_c ? HS_POL : ~HS_POL;
      vsync       <= vs_act_c ? VS_POL : ~VS_POL;
      activevideo <= av_c;
      x_px        <= x_c;
      y_px        <= y_c;
      line_start  <= line_c;
      frame_start <= frame_c;
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
      end else begin
        hc <= hc + CW'(1);
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef FRAME_CNT_EN
  // Counts frames on the same edge that raises frame_start.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      frame_cnt <= 8'd0;
    end else if (px_en && frame_c) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode plus a tiny HS_POL=1 mode, checked against a position-based model.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    bit hpol; bit vpol;
  } mode_t;

  typedef struct packed {
    bit hs; bit vs; bit av; int x; int y; bit ls; bit fs;
  } exp_t;

  localparam mode_t MD = '{640, 24, 40, 128, 480, 9, 3, 28, 1'b0, 1'b0};
  localparam mode_t MS = '{4, 1, 2, 2, 3, 1, 1, 1, 1'b1, 1'b0};

  logic px_clk = 1'b0;
  logic rst_d = 1'b1, en_d = 1'b0, rst_s = 1'b1, en_s = 1'b0;
  logic hs_d, vs_d, av_d, ls_d, fs_d, hs_s, vs_s, av_s, ls_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic [7:0] fc_d, fc_s;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 px_clk = ~px_clk;

  vga_timing_gen dut_d (
    .px_clk(px_clk), .reset(rst_d), .px_en(en_d),
    .hsync(hs_d), .vsync(vs_d), .activevideo(av_d), .x_px(x_d), .y_px(y_d),
    .line_start(ls_d), .frame_start(fs_d)
`ifdef FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_s (
    .px_clk(px_clk), .reset(rst_s), .px_en(en_s),
    .hsync(hs_s), .vsync(vs_s), .activevideo(av_s), .x_px(x_s), .y_px(y_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

`ifndef FRAME_CNT_EN
  assign fc_d = 8'd0;
  assign fc_s = 8'd0;
`endif

  // Outputs for linear pixel index p, counted from the first px_en cycle after reset.
  function automatic exp_t decode(mode_t m, int p);
    int hb, ht, vb, vt, h, v;
    exp_t e;
    hb = m.hfp + m.hsw + m.hbp;
    ht = hb + m.ha;
    vb = m.vfp + m.vsw + m.vbp;
    vt = vb + m.va;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.hs = (h >= m.hfp && h < m.hfp + m.hsw) ? m.hpol : !m.hpol;
    e.vs = (v >= m.vfp && v < m.vfp + m.vsw) ? m.vpol : !m.vpol;
    e.av = (h >= hb) && (v >= vb);
    e.x  = e.av ? h - hb : 0;
    e.y  = e.av ? v - vb : 0;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic exp_t idle(mode_t m);
    exp_t e;
    e = '0;
    e.hs = !m.hpol;
    e.vs = !m.vpol;
    return e;
  endfunction

  exp_t e_d, e_s;
  int   cnt_d = 0, cnt_s = 0, fcm_d = 0, fcm_s = 0;

  always @(posedge px_clk) begin
    if (rst_d) begin e_d = idle(MD); cnt_d = 0; fcm_d = 0; end
    else if (en_d) begin
      e_d = decode(MD, cnt_d);
      if (e_d.fs) fcm_d = (fcm_d + 1) % 256;
      cnt_d++;
    end else begin e_d.ls = 1'b0; e_d.fs = 1'b0; end
    if (rst_s) begin e_s = idle(MS); cnt_s = 0; fcm_s = 0; end
    else if (en_s) begin
      e_s = decode(MS, cnt_s);
      if (e_s.fs) fcm_s = (fcm_s + 1) % 256;
      cnt_s++;
    end else begin e_s.ls = 1'b0; e_s.fs = 1'b0; end
  end

  task automatic cmp(string tag, exp_t e, int efc, logic hs, logic vs, logic av,
                     logic [9:0] x, logic [9:0] y, logic ls, logic fs, logic [7:0] fc);
    bit bad;
    n_vec++;
    bad = (hs !== e.hs) || (vs !== e.vs) || (av !== e.av) || (x !== 10'(e.x)) ||
          (y !== 10'(e.y)) || (ls !== e.ls) || (fs !== e.fs);
`ifdef FRAME_CNT_EN
    bad = bad || (fc !== 8'(efc));
`endif
    if (bad) begin
      n_err++;
      $display("FAIL %s @%0t: got hs=%b vs=%b av=%b x=%0d y=%0d ls=%b fs=%b fc=%0d need hs=%b vs=%b av=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
               tag, $time, hs, vs, av, x, y, ls, fs, fc, e.hs, e.vs, e.av, e.x, e.y, e.ls, e.fs, efc);
    end
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d need %0d", name, act, expv);
    end
  endtask

  always @(negedge px_clk) begin
    if (chk_on) begin
      cmp("model_dflt", e_d, fcm_d, hs_d, vs_d, av_d, x_d, y_d, ls_d, fs_d, fc_d);
      cmp("model_small", e_s, fcm_s, hs_s, vs_s, av_s, x_s, y_s, ls_s, fs_s, fc_s);
    end
  end

  int hlow, hfirst, vlow, lines, frames, avcnt, since, av2, last_x, last_y, hhi, avs, nfs;

  initial begin
    repeat (3) @(negedge px_clk);
    chk_on = 1'b1;
    lit("rst_hsync", hs_d, 1);
    lit("rst_vsync", vs_d, 1);
    lit("rst_av", av_d, 0);
    lit("rst_x", x_d, 0);
    lit("rst_strobes", {ls_d, fs_d}, 0);
    lit("rst_hsync_pol1", hs_s, 0);
`ifdef FRAME_CNT_EN
    lit("rst_fc", fc_d, 0);
`endif

    // Default mode: run to the position hc=191 on line 40.
    hlow = 0; hfirst = -1; vlow = 0; lines = 0; frames = 0; avcnt = 0; since = 0;
    rst_d = 1'b0; en_d = 1'b1;
    for (int k = 0; k <= 40 * 832 + 191; k++) begin
      @(negedge px_clk);
      if (k == 0) begin
        lit("first_fs", fs_d, 1);
        lit("first_ls", ls_d, 1);
        lit("first_hsync", hs_d, 1);
`ifdef FRAME_CNT_EN
        lit("first_fc", fc_d, 1);
`endif
      end
      if (k < 832 && !hs_d) begin hlow++; if (hfirst < 0) hfirst = k; end
      if (!vs_d) vlow++;
      if (ls_d) begin lines++; since = 0; end
      if (fs_d) frames++;
      if (av_d) avcnt++;
      since++;
    end
    lit("hsync_low_len", hlow, 40);
    lit("hsync_first_out", hfirst, 24);
    lit("vsync_low_len", vlow, 2496);
    lit("line_count", lines, 41);
    lit("frame_count", frames, 1);
    lit("av_in_vblank", avcnt, 0);

    en_d = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge px_clk);
      lit("stall_av", av_d, 0);
      lit("stall_strobes", {ls_d, fs_d}, 0);
    end
    en_d = 1'b1;
    av2 = 0; last_x = -1; last_y = -1;
    for (int k = 40 * 832 + 192; k <= 41 * 832; k++) begin
      @(negedge px_clk);
      if (k == 40 * 832 + 192) begin
        lit("resume_av", av_d, 1);
        lit("resume_x", x_d, 0);
        lit("resume_y", y_d, 0);
      end
      if (av_d) begin av2++; last_x = int'(x_d); last_y = int'(y_d); end
      if (ls_d) begin lit("line_len_stall", since, 832); since = 0; end
      since++;
    end
    lit("av_per_line", av2, 640);
    lit("last_x", last_x, 639);
    lit("last_y_row40", last_y, 0);
    en_d = 1'b0;

    // Small mode: H_TOTAL=9, V_TOTAL=6, active-high hsync.
    hhi = 0; avs = 0; nfs = 0;
    rst_s = 1'b0; en_s = 1'b1;
    for (int k = 0; k <= 146; k++) begin
      @(negedge px_clk);
      case (k)
        0:  begin lit("s_hs_idle", hs_s, 0); lit("s_fs0", fs_s, 1); end
        1:  lit("s_hs_pulse", hs_s, 1);
        3:  lit("s_hs_end", hs_s, 0);
        27: lit("s_av_hblank", av_s, 0);
        32: begin lit("s_av_first", av_s, 1); lit("s_x_first", x_s, 0); lit("s_y_first", y_s, 0); end
        53: begin lit("s_av_last", av_s, 1); lit("s_x_last", x_s, 3); lit("s_y_last", y_s, 2); end
        54: lit("s_fs1", fs_s, 1);
        146: lit("s_hs_mid", hs_s, 1);
        default: ;
      endcase
      if (k < 9 && hs_s) hhi++;
      if (k < 54 && av_s) avs++;
      if (fs_s) nfs++;
`ifdef FRAME_CNT_EN
      if (k == 108) lit("s_fc_3", fc_s, 3);
`endif
    end
    lit("s_hs_high_len", hhi, 2);
    lit("s_av_per_frame", avs, 12);
    lit("s_fs_count", nfs, 3);

    rst_s = 1'b1;
    @(negedge px_clk);
    lit("midrst_hsync", hs_s, 0);
    lit("midrst_vsync", vs_s, 1);
    lit("midrst_x", x_s, 0);
    lit("midrst_av", av_s, 0);
    rst_s = 1'b0;

    nfs = 0;
    for (int i = 0; i < 30000 && nfs < 256; i++) begin
      en_s = (i % 4 != 3);
      @(negedge px_clk);
      if (fs_s) begin
        nfs++;
`ifdef FRAME_CNT_EN
        if (nfs == 255) lit("fc_255", fc_s, 255);
        if (nfs == 256) lit("fc_wrap", fc_s, 0);
`endif
      end
    end
    lit("s_frames_seen", nfs, 256);
    en_s = 1'b0;
    @(negedge px_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
